// File: rtl/mem_port_controller.sv
// Memory-port slave: runs one load/store at a time on a word-wide byte-enabled SRAM.
// Byte/half/word at any offset; word-crossing accesses take two SRAM cycles.
module mem_port_controller #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [1:0]        i_width,
    input  logic [31:0]       i_data_wr,
    output logic [31:0]       o_data_rd,
    output logic              o_ready,
    output logic              o_sram_en,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [3:0]        o_sram_be,
    output logic [31:0]       o_sram_wdata,
    input  logic [31:0]       i_sram_rdata
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_t;

    state_t              r_state;
    logic                r_we;
    logic                r_split;
    logic [1:0]          r_off;
    logic [31:0]         r_dmask;
    logic [ADDR_W-1:0]   r_wa1;
    logic [3:0]          r_be_hi;
    logic [31:0]         r_wdata_hi;
    logic [31:0]         r_word0;

    logic                r_ready;
    logic                r_sram_en;
    logic                r_sram_we;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [3:0]          r_sram_be;
    logic [31:0]         r_sram_wdata;

    logic [1:0]          w_off;
    logic [2:0]          w_nbytes;
    logic [7:0]          w_mask8_base;
    logic [31:0]         w_dmask;
    logic [7:0]          w_m8;
    logic [63:0]         w_w64;
    logic                w_split;
    logic [ADDR_W-1:0]   w_wa0;
    logic [ADDR_W-1:0]   w_wa1;
    logic [31:0]         w_rd_lo;
    logic [31:0]         w_rd_shift;
    logic                w_unused_addr;

    // Request decode works on the live inputs; it only matters in the IDLE sampling cycle.
    always_comb begin
        w_off = i_addr[1:0];
        case (i_width)
            2'd0: begin
                w_nbytes     = 3'd1;
                w_mask8_base = 8'h01;
                w_dmask      = 32'h0000_00FF;
            end
            2'd1: begin
                w_nbytes     = 3'd2;
                w_mask8_base = 8'h03;
                w_dmask      = 32'h0000_FFFF;
            end
            default: begin
                w_nbytes     = 3'd4;
                w_mask8_base = 8'h0F;
                w_dmask      = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign w_m8    = w_mask8_base << w_off;
    assign w_w64   = {32'd0, i_data_wr & w_dmask} << {w_off, 3'b000};
    assign w_split = ({1'b0, w_off} + w_nbytes) > 3'd4;
    assign w_wa0   = i_addr[ADDR_W+1:2];
    assign w_wa1   = w_wa0 + ADDR_W'(1);

    assign w_unused_addr = ^i_addr[31:ADDR_W+2];

    // Non-split loads have every byte in the word arriving now; split loads pair it with word0.
    assign w_rd_lo    = r_split ? r_word0 : i_sram_rdata;
    assign w_rd_shift = 32'({i_sram_rdata, w_rd_lo} >> {r_off, 3'b000});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_split      <= 1'b0;
            r_off        <= 2'd0;
            r_dmask      <= 32'd0;
            r_wa1        <= '0;
            r_be_hi      <= 4'd0;
            r_wdata_hi   <= 32'd0;
            r_word0      <= 32'd0;
            r_ready      <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_be    <= 4'd0;
            r_sram_wdata <= 32'd0;
        end else begin
            r_ready      <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_be    <= 4'd0;
            r_sram_wdata <= 32'd0;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_we         <= i_we;
                        r_split      <= w_split;
                        r_off        <= w_off;
                        r_dmask      <= w_dmask;
                        r_wa1        <= w_wa1;
                        r_be_hi      <= w_m8[7:4];
                        r_wdata_hi   <= w_w64[63:32];
                        r_sram_en    <= 1'b1;
                        r_sram_we    <= i_we;
                        r_sram_addr  <= w_wa0;
                        r_sram_be    <= w_m8[3:0];
                        r_sram_wdata <= w_w64[31:0];
                        r_state      <= FIRST;
                    end
                end
                FIRST: begin
                    if (r_split) begin
                        r_sram_en    <= 1'b1;
                        r_sram_we    <= r_we;
                        r_sram_addr  <= r_wa1;
                        r_sram_be    <= r_be_hi;
                        r_sram_wdata <= r_wdata_hi;
                        r_state      <= SECOND;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= RESP;
                    end
                end
                SECOND: begin
                    if (!r_we) begin
                        r_word0 <= i_sram_rdata;
                    end
                    r_ready <= 1'b1;
                    r_state <= RESP;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_sram_en    = r_sram_en;
    assign o_sram_we    = r_sram_we;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_be    = r_sram_be;
    assign o_sram_wdata = r_sram_wdata;
    assign o_data_rd    = (r_state == RESP && !r_we) ? (w_rd_shift & r_dmask) : 32'd0;

endmodule

// File: tb/tb_mem_port_controller.sv
// Randomized bench for mem_port_controller: behavioural SRAM plus a byte-level reference memory.
module tb_mem_port_controller;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned NWORDS = 1 << ADDR_W;
    localparam int unsigned NBYTES = 4 * NWORDS;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              we;
    logic [31:0]       addr;
    logic [1:0]        width;
    logic [31:0]       data_wr;
    logic [31:0]       data_rd;
    logic              ready;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_be;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    logic [31:0] mem [NWORDS];
    logic [7:0]  ref_mem [NBYTES];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_controller #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_we         (we),
        .i_addr       (addr),
        .i_width      (width),
        .i_data_wr    (data_wr),
        .o_data_rd    (data_rd),
        .o_ready      (ready),
        .o_sram_en    (sram_en),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_be    (sram_be),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    // Read data is only meaningful the cycle after a read; other cycles carry garbage.
    always @(posedge clk) begin
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
        else                     sram_rdata <= $urandom;
        if (sram_en && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_be[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int unsigned wa, input logic [31:0] v);
        mem[wa] = v;
        for (int b = 0; b < 4; b++) ref_mem[4*wa + b] = v[8*b +: 8];
    endtask

    task automatic do_req(input logic r_we, input logic [31:0] r_addr, input logic [1:0] r_width,
                          input logic [31:0] r_data, output logic [31:0] rd);
        int unsigned       n, off, lat, exp_lat, nacc, p;
        logic              split, stray;
        logic [ADDR_W-1:0] acc_addr [$];
        logic [3:0]        acc_be [$];
        logic              acc_we [$];
        logic [31:0]       acc_wd [$];
        logic [3:0]        e_be;
        logic [31:0]       e_wd, e_rd;

        n   = (r_width == 2'd0) ? 1 : (r_width == 2'd1) ? 2 : 4;
        off = 32'(r_addr[1:0]);
        @(negedge clk);
        check("idle_quiet", {30'd0, ready, sram_en}, 32'd0);
        valid = 1'b1; we = r_we; addr = r_addr; width = r_width; data_wr = r_data;
        lat = 0; rd = 32'd0; stray = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                valid = 1'($urandom_range(0, 1)); we = 1'($urandom);
                addr = $urandom; width = 2'($urandom); data_wr = $urandom;
            end
            if (sram_en) begin
                acc_addr.push_back(sram_addr); acc_be.push_back(sram_be);
                acc_we.push_back(sram_we);     acc_wd.push_back(sram_wdata);
            end
            if (ready) begin
                lat = cyc;
                rd  = data_rd;
                check("resp_sram_en", 32'(sram_en), 32'd0);
                break;
            end else if (data_rd != 32'd0) begin
                stray = 1'b1;
            end
        end
        valid = 1'b0;

        split   = (off + n) > 4;
        exp_lat = split ? 3 : 2;
        check("latency", lat, exp_lat);
        nacc = split ? 2 : 1;
        check("n_access", acc_addr.size(), nacc);
        for (int j = 0; j < int'(nacc) && j < acc_addr.size(); j++) begin
            e_be = 4'd0; e_wd = 32'd0;
            for (int lane = 0; lane < 4; lane++) begin
                p = 4*j + lane;
                if (p >= off && p < off + n) begin
                    e_be[lane] = 1'b1;
                    e_wd[8*lane +: 8] = r_data[8*(p-off) +: 8];
                end
            end
            check("acc_addr", 32'(acc_addr[j]), ((r_addr >> 2) + j) % NWORDS);
            check("acc_be", 32'(acc_be[j]), 32'(e_be));
            check("acc_we", 32'(acc_we[j]), 32'(r_we));
            check("acc_wdata", acc_wd[j], e_wd);
        end
        if (r_we) begin
            for (int k = 0; k < int'(n); k++) ref_mem[(r_addr + k) % NBYTES] = r_data[8*k +: 8];
            check("store_rd_zero", rd, 32'd0);
        end else begin
            e_rd = 32'd0;
            for (int k = 0; k < int'(n); k++) e_rd[8*k +: 8] = ref_mem[(r_addr + k) % NBYTES];
            check("load_data", rd, e_rd);
        end
        check("rd_outside_resp", 32'(stray), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        saw_ready;
        logic [31:0] ra;

        rst = 1'b1; valid = 1'b0; we = 1'b0; addr = 32'd0; width = 2'd0; data_wr = 32'd0;
        for (int unsigned wa = 0; wa < NWORDS; wa++) set_word(wa, $urandom);
        repeat (2) @(negedge clk);
        check("rst_en", 32'(sram_en), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_be", 32'(sram_be), 32'd0);
        check("rst_wdata", sram_wdata, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data_rd", data_rd, 32'd0);
        rst = 1'b0;

        set_word(4, 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 2'd2, 32'd0, rd);
        check("t_word_load", rd, 32'hDEADBEEF);
        do_req(1'b1, 32'h7, 2'd0, 32'h123456AB, rd);
        do_req(1'b1, 32'h6, 2'd2, 32'hAABBCCDD, rd);
        do_req(1'b0, 32'h4, 2'd2, 32'd0, rd);
        do_req(1'b0, 32'h8, 2'd2, 32'd0, rd);

        set_word(0, 32'h11223344);
        set_word(1, 32'h55667788);
        do_req(1'b0, 32'h3, 2'd1, 32'd0, rd);
        check("t_split_half", rd, 32'h00008811);

        set_word(NWORDS - 1, 32'hAABBCCDD);
        set_word(0, 32'h11223344);
        do_req(1'b0, 32'hFFFE, 2'd2, 32'd0, rd);
        check("t_wrap", rd, 32'h3344AABB);

        // Reset lands in the second cycle of a split store; only the first word was written.
        @(negedge clk);
        valid = 1'b1; we = 1'b1; addr = 32'h6; width = 2'd2; data_wr = 32'hCAFEF00D;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("mid_second_en", 32'(sram_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_en", 32'(sram_en), 32'd0);
        check("arst_we", 32'(sram_we), 32'd0);
        check("arst_addr", 32'(sram_addr), 32'd0);
        check("arst_be", 32'(sram_be), 32'd0);
        check("arst_wdata", sram_wdata, 32'd0);
        ref_mem[6] = 8'h0D;
        ref_mem[7] = 8'hF0;
        saw_ready = ready;
        repeat (3) begin
            @(negedge clk);
            saw_ready = saw_ready | ready;
        end
        check("arst_no_ready", 32'(saw_ready), 32'd0);
        rst = 1'b0;
        do_req(1'b0, 32'h10, 2'd2, 32'd0, rd);
        check("post_rst_load", rd, 32'hDEADBEEF);
        do_req(1'b0, 32'h4, 2'd2, 32'd0, rd);
        do_req(1'b0, 32'h8, 2'd2, 32'd0, rd);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) ra = NBYTES - 8 + $urandom_range(0, 7);
            else                           ra = $urandom_range(0, 255);
            ra = ($urandom & ~(NBYTES - 1)) | ra;
            do_req(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)), $urandom, rd);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
